mcl_rsp_serializer: RTL and testbench

Receive-side stage between the manycore link endpoint and the host AXI-Lite FIFO register decode. It buffers 128-bit `bsg_mcl_response_s` packets arriving from the manycore and serializes them into four 32-bit words for host reads of the receive data register (RDR). It produces the RDFO occupancy, RLR length, host receive-vacancy and receive-complete indications that the register decode returns to the host.

---
 rtl/mcl_rsp_serializer_pkg.sv | 21 ++
 rtl/mcl_rsp_serializer_mem.sv | 26 ++
 rtl/mcl_rsp_serializer.sv | 96 +++++++++
 tb/tb_mcl_rsp_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcl_rsp_serializer_pkg.sv
// Shared widths and the manycore response packet layout for the receive-side serializer.
// The host sees the packet as four 32-bit words, least significant word first.
package mcl_rsp_serializer_pkg;

    localparam int mc_fifo_width_lp   = 128;
    localparam int axil_data_width_lp = 32;
    localparam int rcv_fifo_els_p     = 64;
    localparam int mcl_rsp_words_lp   = mc_fifo_width_lp / axil_data_width_lp;
    localparam int mcl_rsp_bytes_lp   = 16;

    // Field order puts x_cord in the least significant bits, so word 0 = {load_id[15:0], y, x}
    typedef struct packed {
        logic [39:0] padding;
        logic [7:0]  pkt_type;
        logic [31:0] data;
        logic [31:0] load_id;
        logic [7:0]  y_cord;
        logic [7:0]  x_cord;
    } bsg_mcl_response_s;

endpackage

// File: rtl/mcl_rsp_serializer_mem.sv
// Packet storage: one write port, one asynchronous read port, no reset on the array.
module mcl_rsp_serializer_mem
    import mcl_rsp_serializer_pkg::*;
#(
    parameter int els_p   = rcv_fifo_els_p,
    parameter int width_p = mc_fifo_width_lp,
    parameter int addr_w  = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [addr_w-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [addr_w-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i)
            mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/mcl_rsp_serializer.sv
// Buffers 128-bit manycore responses and hands them to the host as 32-bit RDR words,
// with occupancy, length, vacancy and completion status for the register decode.
module mcl_rsp_serializer
    import mcl_rsp_serializer_pkg::*;
#(
    parameter int fifo_els_p   = rcv_fifo_els_p,
    parameter int pkt_width_p  = mc_fifo_width_lp,
    parameter int word_width_p = axil_data_width_lp
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 pkt_v_i,
    input  logic [pkt_width_p-1:0]               pkt_i,
    output logic                                 pkt_ready_o,
    output logic                                 word_v_o,
    output logic [word_width_p-1:0]              word_o,
    input  logic                                 word_yumi_i,
    output logic [$clog2(4*fifo_els_p+1)-1:0]    rdfo_o,
    output logic [31:0]                          rlr_o,
    output logic [$clog2(fifo_els_p+1)-1:0]      vacancy_o,
    output logic                                 rx_complete_o,
    output logic                                 err_o
);

    localparam int ptr_w  = $clog2(fifo_els_p);
    localparam int cnt_w  = $clog2(fifo_els_p+1);
    localparam int rdfo_w = $clog2(4*fifo_els_p+1);
    localparam int idx_w  = $clog2(mcl_rsp_words_lp);

    logic [ptr_w-1:0]       wr_ptr_r, rd_ptr_r;
    logic [cnt_w-1:0]       count_r;
    logic [idx_w-1:0]       word_idx_r;
    logic                   ready_en_r;
    logic                   rx_complete_r;
    logic                   err_r;
    logic [pkt_width_p-1:0] head_pkt;

    logic enq, word_deq, pkt_deq;

    // ready_en_r keeps the buffer closed through reset and opens it the cycle after
    assign pkt_ready_o = ready_en_r & (count_r != cnt_w'(fifo_els_p));
    assign word_v_o    = (count_r != '0);

    assign enq      = pkt_v_i & pkt_ready_o;
    assign word_deq = word_yumi_i & word_v_o;
    assign pkt_deq  = word_deq & (word_idx_r == idx_w'(mcl_rsp_words_lp-1));

    mcl_rsp_serializer_mem #(
        .els_p   (fifo_els_p),
        .width_p (pkt_width_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wr_ptr_r),
        .w_data_i (pkt_i),
        .r_addr_i (rd_ptr_r),
        .r_data_o (head_pkt)
    );

    assign word_o = head_pkt[word_width_p*word_idx_r +: word_width_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            word_idx_r    <= '0;
            ready_en_r    <= 1'b0;
            rx_complete_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            ready_en_r    <= 1'b1;
            rx_complete_r <= pkt_deq;
            if (enq)
                wr_ptr_r <= wr_ptr_r + ptr_w'(1);
            if (word_deq)
                word_idx_r <= word_idx_r + idx_w'(1);
            if (pkt_deq)
                rd_ptr_r <= rd_ptr_r + ptr_w'(1);
            // Enqueue alongside a final-word dequeue leaves the packet count as is
            if (enq & ~pkt_deq)
                count_r <= count_r + cnt_w'(1);
            else if (~enq & pkt_deq)
                count_r <= count_r - cnt_w'(1);
            if (word_yumi_i & ~word_v_o)
                err_r <= 1'b1;
        end
    end

    assign rdfo_o        = rdfo_w'({count_r, 2'b00}) - rdfo_w'(word_idx_r);
    assign rlr_o         = (word_v_o && word_idx_r == '0) ? 32'(mcl_rsp_bytes_lp) : 32'd0;
    assign vacancy_o     = cnt_w'(fifo_els_p) - count_r;
    assign rx_complete_o = rx_complete_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_mcl_rsp_serializer.sv
// Directed bench for mcl_rsp_serializer: known-answer packet, fill/full corner, random-stall
// stream against a word scoreboard, underrun and mid-packet reset.
module tb_mcl_rsp_serializer;
    import mcl_rsp_serializer_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         pkt_v_i;
    logic [127:0] pkt_i;
    logic         pkt_ready_o;
    logic         word_v_o;
    logic [31:0]  word_o;
    logic         word_yumi_i;
    logic [8:0]   rdfo_o;
    logic [31:0]  rlr_o;
    logic [6:0]   vacancy_o;
    logic         rx_complete_o;
    logic         err_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb[$];

    always #5 clk_i = ~clk_i;

    mcl_rsp_serializer dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .pkt_v_i       (pkt_v_i),
        .pkt_i         (pkt_i),
        .pkt_ready_o   (pkt_ready_o),
        .word_v_o      (word_v_o),
        .word_o        (word_o),
        .word_yumi_i   (word_yumi_i),
        .rdfo_o        (rdfo_o),
        .rlr_o         (rlr_o),
        .vacancy_o     (vacancy_o),
        .rx_complete_o (rx_complete_o),
        .err_o         (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [7:0] x, input logic [7:0] y,
                                        input logic [31:0] id, input logic [31:0] d,
                                        input logic [7:0] t);
        bsg_mcl_response_s p;
        p = '0;
        p.x_cord = x; p.y_cord = y; p.load_id = id; p.data = d; p.pkt_type = t;
        return p;
    endfunction

    task automatic sb_push(input logic [127:0] p);
        for (int k = 0; k < 4; k++) sb.push_back(p[32*k +: 32]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_word_v"}, word_v_o, 0);
        chk({tag, "_rdfo"}, rdfo_o, 0);
        chk({tag, "_rlr"}, rlr_o, 0);
        chk({tag, "_vacancy"}, vacancy_o, 64);
        chk({tag, "_rx"}, rx_complete_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        logic [31:0]  exp_w [4];
        logic [127:0] cur;
        int sent, got, cyc;
        logic exp_rx;

        reset_i = 1'b1; pkt_v_i = 1'b0; pkt_i = '0; word_yumi_i = 1'b0;

        // Reset, then idle
        tick(); tick(); tick();
        chk("rst_ready", pkt_ready_o, 0);
        chk_reset_outputs("rst");
        reset_i = 1'b0;
        tick();
        chk("idle_ready", pkt_ready_o, 1);
        chk_reset_outputs("idle");

        // Single known-answer packet
        exp_w[0] = 32'h1234_0302; exp_w[1] = 32'hBEEF_A5A5;
        exp_w[2] = 32'h0001_DEAD; exp_w[3] = 32'h0000_0000;
        pkt_i = mk(8'd2, 8'd3, 32'hA5A5_1234, 32'hDEAD_BEEF, 8'd1);
        pkt_v_i = 1'b1;
        tick();
        pkt_v_i = 1'b0;
        chk("one_vacancy", vacancy_o, 63);
        chk("one_word_v", word_v_o, 1);
        for (int i = 0; i < 4; i++) begin
            chk("one_word", word_o, exp_w[i]);
            chk("one_rdfo", rdfo_o, 32'(4 - i));
            chk("one_rlr", rlr_o, (i == 0) ? 32'd16 : 32'd0);
            chk("one_rx_quiet", rx_complete_o, 0);
            word_yumi_i = 1'b1;
            tick();
            word_yumi_i = 1'b0;
        end
        chk("one_rx_pulse", rx_complete_o, 1);
        chk("one_rdfo_end", rdfo_o, 0);
        chk("one_word_v_end", word_v_o, 0);
        tick();
        chk("one_rx_single", rx_complete_o, 0);

        // Fill to 64 packets, hold a 65th on the input
        for (int i = 0; i < 64; i++) begin
            pkt_i = mk(8'(i), 8'h5A, 32'hC000_0000 + 32'(i), 32'(i * 3), 8'd2);
            sb_push(pkt_i);
            pkt_v_i = 1'b1;
            tick();
        end
        pkt_i = mk(8'd64, 8'h77, 32'hC000_0040, 32'h0BAD_F00D, 8'd3);
        chk("full_ready", pkt_ready_o, 0);
        chk("full_vacancy", vacancy_o, 0);
        chk("full_rdfo", rdfo_o, 256);
        for (int k = 0; k < 3; k++) begin
            chk("full_word", word_o, sb.pop_front());
            word_yumi_i = 1'b1;
            tick();
            chk("full_ready_hold", pkt_ready_o, 0);
        end
        chk("full_rdfo_253", rdfo_o, 253);
        // Final word of head while full and pkt_v_i held: packet must not be taken yet
        chk("full_word3", word_o, sb.pop_front());
        tick();
        word_yumi_i = 1'b0;
        chk("simul_ready", pkt_ready_o, 1);
        chk("simul_rdfo", rdfo_o, 252);
        chk("simul_vacancy", vacancy_o, 1);
        chk("simul_rx", rx_complete_o, 1);
        tick();
        sb_push(pkt_i);
        pkt_v_i = 1'b0;
        chk("refill_ready", pkt_ready_o, 0);
        chk("refill_vacancy", vacancy_o, 0);
        chk("refill_rdfo", rdfo_o, 256);
        chk("refill_rx", rx_complete_o, 0);

        // Drain everything in order at one word per cycle
        while (sb.size() != 0) begin
            chk("drain_word", word_o, sb.pop_front());
            word_yumi_i = 1'b1;
            tick();
        end
        word_yumi_i = 1'b0;
        chk("drain_word_v", word_v_o, 0);
        chk("drain_rx", rx_complete_o, 1);
        tick();
        chk("drain_rx_off", rx_complete_o, 0);

        // Random-stall stream of 200 packets across pointer wrap
        sent = 0; got = 0; cyc = 0; exp_rx = 1'b0;
        cur = {$urandom, $urandom, $urandom, $urandom};
        while ((sent < 200 || got < 800) && cyc < 20000) begin
            chk("wrap_rdfo", rdfo_o, 32'(sb.size()));
            chk("wrap_vacancy", vacancy_o, 32'(64 - (sb.size() + 3) / 4));
            chk("wrap_rx", rx_complete_o, exp_rx);
            exp_rx = 1'b0;
            pkt_v_i = (sent < 200) && ($urandom_range(0, 3) != 0);
            pkt_i = cur;
            word_yumi_i = word_v_o && ($urandom_range(0, 2) != 0);
            if (word_yumi_i) begin
                if (sb.size() == 0) chk("wrap_extra_word", word_v_o, 0);
                else chk("wrap_word", word_o, sb.pop_front());
                got++;
                exp_rx = (got % 4 == 0);
            end
            if (pkt_v_i && pkt_ready_o) begin
                sb_push(cur);
                sent++;
                cur = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            cyc++;
        end
        pkt_v_i = 1'b0; word_yumi_i = 1'b0;
        chk("wrap_words_done", got, 800);
        chk("wrap_rx_last", rx_complete_o, exp_rx);
        tick();
        chk("wrap_empty", word_v_o, 0);

        // Underrun sets sticky error without touching state
        chk("pre_err", err_o, 0);
        word_yumi_i = 1'b1;
        tick();
        word_yumi_i = 1'b0;
        chk("under_err", err_o, 1);
        chk("under_rdfo", rdfo_o, 0);
        chk("under_word_v", word_v_o, 0);
        tick();
        chk("under_err_sticky", err_o, 1);

        // Reset after two words of a packet
        pkt_i = mk(8'd9, 8'd8, 32'h1111_2222, 32'h3333_4444, 8'd5);
        pkt_v_i = 1'b1;
        tick();
        pkt_v_i = 1'b0;
        word_yumi_i = 1'b1;
        tick(); tick();
        word_yumi_i = 1'b0;
        chk("mid_rdfo", rdfo_o, 2);
        chk("mid_rlr", rlr_o, 0);
        reset_i = 1'b1;
        tick();
        chk("mid_rst_ready", pkt_ready_o, 0);
        chk_reset_outputs("mid_rst");
        reset_i = 1'b0;
        tick();
        chk("post_rst_ready", pkt_ready_o, 1);
        chk_reset_outputs("post_rst");
        pkt_i = mk(8'd1, 8'd4, 32'hABCD_0007, 32'h0, 8'd0);
        pkt_v_i = 1'b1;
        tick();
        pkt_v_i = 1'b0;
        chk("post_rst_word0", word_o, 32'h0007_0401);
        chk("post_rst_rlr", rlr_o, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
